// File: rtl/wb_sram_slave_if.sv
// Wishbone data-bus bundle between the interconnect slave port and wb_sram_slave.
// The master modport is the interconnect side; the slave modport is the SRAM controller side.
interface wb_sram_slave_if #(
  parameter int BL_WIDTH = 10
);
  logic                cyc;
  logic                stb;
  logic                we;
  logic [31:0]         adr;
  logic [3:0]          sel;
  logic [31:0]         dat_w;
  logic [BL_WIDTH-1:0] bl;
  logic [31:0]         dat_r;
  logic                ack;
  logic                lack;
  logic                err;

  modport master (
    output cyc, stb, we, adr, sel, dat_w, bl,
    input  dat_r, ack, lack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w, bl,
    output dat_r, ack, lack, err
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone slave that turns single and incrementing-burst transfers into accesses on a
// one-cycle-latency synchronous SRAM, with wait states, range/alignment errors and last-ack.
module wb_sram_slave #(
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int WAIT_STATES    = 0,
  parameter int BL_WIDTH       = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  wb_sram_slave_if.slave            wbd,
  output logic                      mem_cs_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_wmask_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam int AW    = MEM_ADDR_WIDTH;
  localparam int SUM_W = ((AW > BL_WIDTH) ? AW : BL_WIDTH) + 1;
  localparam int WS_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       base_q, base_d;
  logic                we_q, we_d;
  logic [BL_WIDTH-1:0] beats_q, beats_d;
  logic [BL_WIDTH-1:0] beat_q, beat_d;
  logic [WS_W-1:0]     wait_q, wait_d;
  logic [31:0]         dat_q, dat_d;

  logic                req;
  logic                adr_bad;
  logic                last_beat;
  logic [SUM_W-1:0]    next_word;
  logic                next_oob;

  assign req       = wbd.cyc & wbd.stb;
  assign adr_bad   = (wbd.adr[1:0] != 2'b00) | (wbd.adr[31:AW+2] != '0);
  assign last_beat = (beat_q == (beats_q - 1'b1));

  // Word address of the following beat, one bit wider than the SRAM so running off the
  // top of the array is visible instead of silently wrapping to word 0.
  assign next_word = SUM_W'(base_q) + SUM_W'(beat_q) + SUM_W'(1);
  assign next_oob  = (next_word[SUM_W-1:AW] != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      we_q    <= 1'b0;
      beats_q <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      we_q    <= we_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      dat_q   <= dat_d;
    end
  end

  // NOTE: every variable gets a hold/default value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    we_d    = we_q;
    beats_d = beats_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    dat_d   = dat_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d  = wbd.adr[AW+1:2];
          we_d    = wbd.we;
          beats_d = (wbd.bl == '0) ? BL_WIDTH'(1) : wbd.bl;
          beat_d  = '0;
          wait_d  = '0;
          state_d = adr_bad ? S_ERR : S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = wbd.cyc ? S_CAPT : S_IDLE;
      end

      S_CAPT: begin
        if (!wbd.cyc) begin
          state_d = S_IDLE;
        end else begin
          if (!we_q) begin
            dat_d = mem_rdata_i;
          end
          wait_d  = '0;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end

      S_WAIT: begin
        if (!wbd.cyc) begin
          state_d = S_IDLE;
        end else if (wait_q == WS_W'(WAIT_STATES - 1)) begin
          state_d = S_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_RESP: begin
        if (!wbd.cyc || last_beat) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + 1'b1;
          state_d = next_oob ? S_ERR : S_ISSUE;
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode from the registered state; cyc gating makes an abort take effect
  // in the same cycle, so a dropped cycle never writes the SRAM or acks.
  always_comb begin
    wbd.ack  = 1'b0;
    wbd.lack = 1'b0;
    wbd.err  = 1'b0;
    mem_cs_o = 1'b0;
    mem_we_o = 1'b0;

    case (state_q)
      S_ISSUE: begin
        mem_cs_o = wbd.cyc;
        mem_we_o = wbd.cyc & we_q;
      end
      S_RESP: begin
        wbd.ack  = wbd.cyc;
        wbd.lack = wbd.cyc & last_beat;
      end
      S_ERR: begin
        wbd.err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem_addr_o  = base_q + AW'(beat_q);
  assign mem_wdata_o = wbd.dat_w;
  assign mem_wmask_o = wbd.sel;
  assign wbd.dat_r   = dat_q;

endmodule
